// File: rtl/ahb_master_if.sv
// ahb_master_if: single-master AHB initiator behind a valid/ready command port.
// Define AHB_MASTER_WATCHDOG_EN to enable the data-phase wait-state watchdog.
module ahb_master_if #(
    parameter int MAX_RETRY      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [13:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    input  logic        cmd_lock,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        HBUSREQ,
    output logic        HLOCK,
    input  logic        HGRANT,
    output logic [13:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [1:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [7:0]  HWDATA,
    input  logic [7:0]  HRDATA,
    input  logic        HREADY,
    input  logic [1:0]  HRESP
);

    localparam logic [1:0] HT_NONSEQ = 2'd0;
    localparam logic [1:0] HT_IDLE   = 2'd3;
    localparam logic [1:0] RSP_OKAY  = 2'b00;
    localparam logic [1:0] RSP_ERROR = 2'b01;

    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            wr_q, wr_d;
    logic [13:0]     addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            lock_q, lock_d;
    logic [RW-1:0]   rty_q, rty_d, rty_inc;
    logic            busreq_q, busreq_d;
    logic            hlock_q, hlock_d;
    logic [13:0]     haddr_q, haddr_d;
    logic [1:0]      htrans_q, htrans_d;
    logic            hwrite_q, hwrite_d;
    logic [7:0]      hwdata_q, hwdata_d;
    logic            rvalid_q, rvalid_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            rerr_q, rerr_d;

`ifdef AHB_MASTER_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0]   wd_q, wd_d;
`endif

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = rvalid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rerr_q;
    assign HBUSREQ   = busreq_q;
    assign HLOCK     = hlock_q;
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = 2'b00;
    assign HBURST    = 3'b000;
    assign HWDATA    = hwdata_q;

    // State and registered bus/user outputs, synchronous active-low reset
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lock_q   <= 1'b0;
            rty_q    <= '0;
            busreq_q <= 1'b0;
            hlock_q  <= 1'b0;
            haddr_q  <= '0;
            htrans_q <= HT_IDLE;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
`ifdef AHB_MASTER_WATCHDOG_EN
            wd_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lock_q   <= lock_d;
            rty_q    <= rty_d;
            busreq_q <= busreq_d;
            hlock_q  <= hlock_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
`ifdef AHB_MASTER_WATCHDOG_EN
            wd_q     <= wd_d;
`endif
        end
    end

    // Next-state and next-output decode for the transfer sequence
    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lock_d   = lock_q;
        rty_d    = rty_q;
        rty_inc  = rty_q + RW'(1);
        busreq_d = busreq_q;
        hlock_d  = hlock_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hwdata_d = hwdata_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
`ifdef AHB_MASTER_WATCHDOG_EN
        wd_d     = '0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    wr_d     = cmd_write;
                    addr_d   = cmd_addr;
                    wdata_d  = cmd_wdata;
                    lock_d   = cmd_lock;
                    busreq_d = 1'b1;
                    hlock_d  = cmd_lock;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (HGRANT && HREADY) begin
                    haddr_d  = addr_q;
                    htrans_d = HT_NONSEQ;
                    hwrite_d = wr_q;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    htrans_d = HT_IDLE;
                    if (wr_q) begin
                        hwdata_d = wdata_q;
                    end
                    busreq_d = lock_q;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (HRESP == RSP_ERROR) begin
                    rerr_d   = 1'b1;
                    rvalid_d = 1'b1;
                    state_d  = S_DONE;
                end else if (HRESP[1]) begin
                    // RETRY and SPLIT both re-arbitrate; SPLIT just sees a late grant
                    rty_d = rty_inc;
                    if (rty_inc > RW'(MAX_RETRY)) begin
                        rerr_d   = 1'b1;
                        rvalid_d = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        busreq_d = 1'b1;
                        state_d  = S_REQ;
                    end
                end else if (HREADY) begin
                    if (!wr_q) begin
                        rdata_d = HRDATA;
                    end
                    rerr_d   = 1'b0;
                    rvalid_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
`ifdef AHB_MASTER_WATCHDOG_EN
                    if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                        rerr_d   = 1'b1;
                        rvalid_d = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        wd_d = wd_q + WW'(1);
                    end
`endif
                end
            end
            S_DONE: begin
                busreq_d = 1'b0;
                hlock_d  = 1'b0;
                rty_d    = '0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/ahb_master_if.md
Name: ahb_master_if

Overview:
- Single-master AHB initiator; the requesting end of the bus that the codebase's 2K AHB slaves answer.
- Accepts one command at a time on a simple valid/ready user port.
- Arbitrates for the bus (HBUSREQ/HGRANT) and runs single 8-bit transfers.
- Handles OKAY/ERROR/RETRY/SPLIT responses and returns read data or error status to the user port.

Parameters:
- MAX_RETRY, 4: RETRY/SPLIT re-attempts allowed before the command completes with error.
- TIMEOUT_CYCLES, 16: data-phase wait-state limit; used only with the optional feature.

Ports:
- HCLK  in  1  bus clock; all logic on the rising edge.
- HRESETn  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle, can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  14  [13:12] slave select, [11:0] slave address.
- cmd_wdata  in  8  write data.
- cmd_lock  in  1  request a locked transfer.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data, valid with rsp_valid.
- rsp_err  out  1  completion with error, valid with rsp_valid.
- HBUSREQ  out  1  bus request to arbiter.
- HLOCK  out  1  lock request to arbiter.
- HGRANT  in  1  grant from arbiter.
- HADDR  out  14  address.
- HTRANS  out  2  transfer type; codebase encoding NON_SEQ=0, SEQ=1, BUSY=2, IDLE=3.
- HWRITE  out  1  transfer direction.
- HSIZE  out  2  tied 2'b00 (8-bit).
- HBURST  out  3  tied 3'b000 (single transfer).
- HWDATA  out  8  write data.
- HRDATA  in  8  read data from the read mux.
- HREADY  in  1  bus ready.
- HRESP  in  2  OKAY=00, ERROR=01, RETRY=10, SPLIT=11.

Behaviour:
- Reset (HRESETn=0 at a rising edge):
  - State goes to IDLE.
  - Outputs: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, HBUSREQ=0, HLOCK=0, HADDR=0, HTRANS=IDLE(3), HWRITE=0, HWDATA=0.
  - Retry count clears.
  - Reset mid-transfer abandons the command silently; no rsp_valid is produced.
- States: IDLE, REQ, ADDR, DATA, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch write/addr/wdata/lock, cmd_ready=0, HBUSREQ=1, HLOCK=cmd_lock, go to REQ.
- REQ:
  - Hold HBUSREQ.
  - On HGRANT=1 && HREADY=1 sampled: drive HADDR=latched addr, HTRANS=NON_SEQ, HWRITE, go to ADDR.
  - Otherwise wait indefinitely.
- ADDR:
  - While HREADY=0, hold the address phase unchanged.
  - On HREADY=1: HTRANS=IDLE; HWDATA=latched wdata if write; HBUSREQ=0 unless locked; go to DATA.
- DATA, sampled each edge:
  - HREADY=1, HRESP=OKAY: capture HRDATA into rsp_rdata (reads only), rsp_err=0, go to DONE.
  - HRESP=ERROR (any HREADY): rsp_err=1, go to DONE.
  - HRESP=RETRY or SPLIT (any HREADY):
    - Increment retry count.
    - If count exceeds MAX_RETRY: rsp_err=1, go to DONE.
    - Else: HTRANS stays IDLE, HBUSREQ=1, go to REQ and re-issue the same address/data.
    - For SPLIT, the arbiter masks HGRANT until the slave's HSPLITx; the master just waits in REQ.
  - HREADY=0, HRESP=OKAY: wait state, stay in DATA.
- DONE:
  - rsp_valid=1 for exactly one cycle.
  - Release HBUSREQ and HLOCK, clear retry count, go to IDLE; cmd_ready=1 on the following cycle.
- Latency, no wait states, grant already high: cmd accept → rsp_valid = 4 cycles (REQ, ADDR, DATA, DONE).
- cmd_valid while busy is ignored (cmd_ready=0).
- HGRANT dropping while in ADDR/DATA has no effect on the current transfer.
- HLOCK stays asserted across retries of a locked command.

Optional Feature:
- Macro: AHB_MASTER_WATCHDOG_EN.
- Defined:
  - A counter of consecutive DATA-state cycles with HREADY=0 and HRESP=OKAY is kept.
  - On reaching TIMEOUT_CYCLES, the command completes with rsp_err=1 via DONE and the bus is released.
  - Counter clears on leaving DATA.
- Undefined: no counter; the master waits indefinitely on HREADY=0.

Test Plan:
- Write, cmd_addr=14'h0005, wdata=8'hA5, HGRANT rises 2 cycles after request, HREADY=1, HRESP=OKAY → HTRANS=0 for one cycle with HADDR=0005; HWDATA=A5 in data phase; rsp_valid pulse with rsp_err=0; HBUSREQ low after DONE.
- Read addr 14'h0002, slave returns HRDATA=8'd30 after 2 wait states → rsp_rdata=30, rsp_err=0; rsp_valid 2 cycles later than the zero-wait case.
- Read addr 0, slave answers SPLIT; HGRANT withheld 5 cycles, then regranted; second attempt OKAY with HRDATA=8'd10 → address phase re-issued once, rsp_rdata=10, single rsp_valid.
- MAX_RETRY=4, slave answers RETRY 5 consecutive times → exactly 5 address phases, then rsp_valid with rsp_err=1.
- HRESP=ERROR on a write → rsp_err=1; HRESETn=0 asserted during DATA of the next command → all outputs at reset values next edge, no rsp_valid.
- With AHB_MASTER_WATCHDOG_EN, TIMEOUT_CYCLES=16, HREADY held 0 → rsp_err=1 after 16 data-phase cycles; without the macro, still waiting at cycle 100.
